// File: rtl/weighted_pop_scheduler.sv
// Weighted round-robin pop controller feeding a 2-entry valid/ready output buffer.
// Pop-to-out_valid: 2 edges; pops stall while buffer plus in-flight word would exceed 2.
module weighted_pop_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int BUF_WIDTH      = 3,
  parameter int MAX_WEIGHT     = 64,
  localparam int W  = $clog2(MAX_WEIGHT),
  localparam int SW = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY*W-1:0]         pesos,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [SW-1:0]                       selector,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [W:0]          credit_q, credit_d;
  logic                fresh_q, fresh_d;
  logic [W-1:0]        weight [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] elig;
  logic                found;
  logic [SW-1:0]       next_q;

  logic                inflight_q;
  logic [SW-1:0]       inflight_idx_q;
  logic [DATA_BITS-1:0] buf_mem [2];
  logic                rd_idx_q, wr_idx_q;
  logic [1:0]          cnt_q;
  logic                rd_en;
  logic [2:0]          occ;
  logic                space;
  logic                do_pop;
  logic                turn_end;

  always_comb begin
    for (int n = 0; n < QUEUE_QUANTITY; n++) begin
      weight[n] = pesos[n*W +: W];
      elig[n]   = !buf_empty[n] && (weight[n] != '0);
    end
  end

  // After reset the search starts at ptr itself so q0 is served first;
  // afterwards ptr is examined last so a lone eligible queue re-wins.
  always_comb begin
    found  = 1'b0;
    next_q = ptr_q;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      int idx;
      idx = (int'(ptr_q) + i + (fresh_q ? 0 : 1)) % QUEUE_QUANTITY;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        next_q = SW'(idx);
      end
    end
  end

  assign rd_en = (cnt_q != 2'd0) && out_ready;
  assign occ   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, rd_en};
  assign space = (occ < 3'd2);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    fresh_d  = fresh_q;
    pop      = '0;
    do_pop   = 1'b0;
    turn_end = 1'b0;
    if (enb) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            ptr_d    = next_q;
            credit_d = {1'b0, weight[next_q]};
            fresh_d  = 1'b0;
            state_d  = SERVE;
          end
        end
        SERVE: begin
          do_pop   = space && !buf_empty[ptr_q] && (credit_q != '0);
          turn_end = (do_pop && (credit_q == (W+1)'(1))) || buf_empty[ptr_q] ||
                     (credit_q == '0);
          if (do_pop) begin
            pop[ptr_q] = 1'b1;
            credit_d   = credit_q - 1'b1;
          end
          if (turn_end) begin
            if (found) begin
              ptr_d    = next_q;
              credit_d = {1'b0, weight[next_q]};
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      credit_q       <= '0;
      fresh_q        <= 1'b1;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      credit_q       <= credit_d;
      fresh_q        <= fresh_d;
      inflight_q     <= do_pop;
      inflight_idx_q <= ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < 2; e++) buf_mem[e] <= '0;
      rd_idx_q <= 1'b0;
      wr_idx_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_mem[wr_idx_q] <= fifo_data[int'(inflight_idx_q)*DATA_BITS +: DATA_BITS];
        wr_idx_q          <= ~wr_idx_q;
      end
      if (rd_en) rd_idx_q <= ~rd_idx_q;
      cnt_q <= cnt_q + 2'(inflight_q) - 2'(rd_en);
    end
  end

  assign selector  = ptr_q;
  assign data_out  = buf_mem[rd_idx_q];
  assign out_valid = (cnt_q != 2'd0);
  assign busy      = inflight_q || out_valid;

endmodule

// File: tb/tb_weighted_pop_scheduler.sv
// Scoreboard bench: FIFO model supplies words, expected data queued on each pop.
module tb_weighted_pop_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [23:0] pesos;
  logic [3:0]  buf_empty;
  logic [31:0] fifo_data;
  logic [3:0]  pop;
  logic [1:0]  selector;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  weighted_pop_scheduler dut (
    .clk(clk), .rst(rst), .enb(enb), .pesos(pesos), .buf_empty(buf_empty),
    .fifo_data(fifo_data), .pop(pop), .selector(selector), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fmem [4][64];
  int         fhead [4];
  int         fcnt [4];
  int         wseq [4];
  logic [7:0] sb [$];
  int         pop_log [$];
  int         nout, ncyc, first_pop, last_pop, gaps;
  logic       seen_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] wts(input int a, input int b, input int c, input int d);
    return {d[5:0], c[5:0], b[5:0], a[5:0]};
  endfunction

  task automatic refresh();
    for (int n = 0; n < 4; n++) buf_empty[n] = (fcnt[n] == 0);
  endtask

  task automatic fill(input int n, input int k);
    for (int j = 0; j < k; j++) begin
      fmem[n][(fhead[n] + fcnt[n]) % 64] = {n[1:0], wseq[n][5:0]};
      wseq[n]++;
      fcnt[n]++;
    end
    refresh();
  endtask

  task automatic clear_logs();
    sb.delete();
    pop_log.delete();
    nout = 0; first_pop = -1; last_pop = -1; gaps = 0; seen_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; enb = 1'b0; out_ready = 1'b1; fifo_data = '0;
    for (int n = 0; n < 4; n++) begin fhead[n] = 0; fcnt[n] = 0; wseq[n] = 0; end
    refresh();
    clear_logs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock: observe outputs at negedge, then apply FIFO pops just after the edge.
  task automatic cycle();
    int qi;
    logic [3:0] p;
    qi = -1;
    @(negedge clk);
    p = pop;
    check("pop_onehot", 32'($countones(p) <= 1), 1);
    if (p != 4'd0) begin
      for (int n = 0; n < 4; n++) if (p[n]) qi = n;
      check("sel_vs_pop", selector, qi);
      check("pop_nonempty", 32'(fcnt[qi] != 0), 1);
      pop_log.push_back(qi);
      sb.push_back(fmem[qi][fhead[qi]]);
      if (first_pop < 0) first_pop = ncyc;
      last_pop = ncyc;
    end
    if (seen_valid && !out_valid) gaps++;
    if (out_valid) seen_valid = 1'b1;
    if (out_valid && out_ready) begin
      nout++;
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else check("data_out", data_out, sb.pop_front());
    end
    @(posedge clk);
    #1;
    if (qi >= 0 && fcnt[qi] != 0) begin
      fifo_data[qi*8 +: 8] = fmem[qi][fhead[qi]];
      fhead[qi] = (fhead[qi] + 1) % 64;
      fcnt[qi]--;
    end
    refresh();
    ncyc++;
  endtask

  task automatic drain(input string tag);
    enb = 1'b0; out_ready = 1'b1;
    repeat (6) cycle();
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic check_seq(input string tag, input int exp[], input int n);
    check({tag, "_npops"}, 32'(pop_log.size() >= n), 1);
    for (int i = 0; i < n && i < pop_log.size(); i++)
      check(tag, pop_log[i], exp[i % exp.size()]);
  endtask

  initial begin
    int e1[] = '{0, 0, 0, 1, 2, 2, 3};
    int e3[] = '{0, 2, 3};
    int e5[] = '{0, 0, 0, 1};
    int n0;
    ncyc = 0;
    pesos = '0;

    // Reset values
    rst = 1'b0; enb = 1'b0; out_ready = 1'b1; fifo_data = '0; buf_empty = '1;
    #1;
    check("rst_pop", pop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", selector, 0);

    // Weighted rotation, all queues full
    do_reset();
    pesos = wts(3, 1, 2, 1);
    for (int n = 0; n < 4; n++) fill(n, 20);
    enb = 1'b1;
    for (int k = 0; k < 40 && pop_log.size() < 14; k++) cycle();
    check_seq("t1_seq", e1, 14);
    check("t1_no_idle", last_pop - first_pop, 13);
    check("t1_valid_gaps", gaps, 0);
    drain("t1");

    // Lone queue re-wins its own turn, then goes idle
    do_reset();
    pesos = wts(1, 1, 2, 1);
    fill(2, 5);
    enb = 1'b1;
    repeat (20) cycle();
    check("t2_npops", pop_log.size(), 5);
    for (int i = 0; i < pop_log.size(); i++) check("t2_q", pop_log[i], 2);
    check("t2_contig", last_pop - first_pop, 4);
    check("t2_nout", nout, 5);
    check("t2_busy", busy, 0);
    drain("t2");

    // Zero-weight queue skipped
    do_reset();
    pesos = wts(1, 0, 1, 1);
    for (int n = 0; n < 4; n++) fill(n, 20);
    enb = 1'b1;
    for (int k = 0; k < 30 && pop_log.size() < 6; k++) cycle();
    check_seq("t3_seq", e3, 6);
    drain("t3");

    // Backpressure: exactly two pops, head held, then 1/cycle
    do_reset();
    pesos = wts(3, 1, 2, 1);
    for (int n = 0; n < 4; n++) fill(n, 20);
    out_ready = 1'b0;
    enb = 1'b1;
    repeat (10) cycle();
    check("t4_npops", pop_log.size(), 2);
    check("t4_valid", out_valid, 1);
    check("t4_head", data_out, sb[0]);
    repeat (3) cycle();
    check("t4_head_hold", data_out, sb[0]);
    check("t4_still2", pop_log.size(), 2);
    out_ready = 1'b1;
    n0 = pop_log.size();
    repeat (10) cycle();
    check("t4_resume", pop_log.size() - n0, 10);
    drain("t4");

    // Asynchronous reset mid-burst
    do_reset();
    pesos = wts(3, 1, 2, 1);
    for (int n = 0; n < 4; n++) fill(n, 20);
    enb = 1'b1;
    repeat (5) cycle();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_pop", pop, 0);
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_sel", selector, 0);
    @(posedge clk);
    #1;
    clear_logs();
    rst = 1'b1;
    repeat (6) cycle();
    check_seq("t5_seq", e5, 4);
    drain("t5");

    // Enable dropped mid-turn with credit 2 left
    do_reset();
    pesos = wts(3, 1, 2, 1);
    for (int n = 0; n < 4; n++) fill(n, 20);
    enb = 1'b1;
    cycle();
    cycle();
    check("t6_first", pop_log.size(), 1);
    enb = 1'b0;
    repeat (3) cycle();
    check("t6_frozen", pop_log.size(), 1);
    check("t6_drained", nout, 1);
    enb = 1'b1;
    repeat (3) cycle();
    check("t6_total", pop_log.size(), 4);
    check_seq("t6_seq", e5, 4);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
